// File: rtl/ps2_tx_if.sv
// Command-byte handshake between a host-side producer and the PS/2 transmitter.
// valid/ready: a byte transfers on a rising clock edge where tx_valid and tx_ready are both high;
// tx_valid is ignored while tx_ready is low.
interface ps2_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/ps2_tx.sv
// Host-to-keyboard PS/2 command transmitter: inhibits the bus, issues a request-to-send,
// shifts a byte out on device clock falls, and checks the device ACK with a timeout.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK_CPU,
    input  logic       resetp,
    ps2_tx_if.slave    tx_if,
    input  logic       keyboard_clock,
    input  logic       keyboard_data,
    output logic       kb_clock_oe,
    output logic       kb_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [2:0] dbg_state_o
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t        state_q;
    logic [9:0]    frame_q;
    logic [3:0]    bit_cnt_q;
    logic [CW-1:0] cnt_q;
    logic          clk_s1_q, clk_s2_q, clk_h_q;
    logic          dat_s1_q, dat_s2_q;
    logic          kb_clock_oe_q, kb_data_oe_q;
    logic          tx_ready_q, busy_q, tx_done_q, tx_error_q;

    logic clk_fall;
    assign clk_fall = clk_h_q & ~clk_s2_q;

    always_ff @(posedge CLK_CPU) begin
        if (resetp) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            bit_cnt_q     <= '0;
            cnt_q         <= '0;
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            clk_h_q       <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            kb_clock_oe_q <= 1'b0;
            kb_data_oe_q  <= 1'b0;
            tx_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_error_q    <= 1'b0;
        end else begin
            clk_s1_q   <= keyboard_clock;
            clk_s2_q   <= clk_s1_q;
            clk_h_q    <= clk_s2_q;
            dat_s1_q   <= keyboard_data;
            dat_s2_q   <= dat_s1_q;
            tx_done_q  <= 1'b0;
            tx_error_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (tx_if.tx_valid) begin
                        frame_q       <= {1'b1, ~^tx_if.tx_data, tx_if.tx_data};
                        cnt_q         <= '0;
                        bit_cnt_q     <= '0;
                        kb_clock_oe_q <= 1'b1;
                        kb_data_oe_q  <= 1'b0;
                        tx_ready_q    <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt_q == INH_LAST) begin
                        cnt_q        <= '0;
                        kb_data_oe_q <= 1'b1;
                        state_q      <= START;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                START: begin
                    // Releasing the clock with data held low is the request-to-send (start bit).
                    kb_clock_oe_q <= 1'b0;
                    kb_data_oe_q  <= 1'b1;
                    cnt_q         <= '0;
                    bit_cnt_q     <= '0;
                    state_q       <= SHIFT;
                end
                SHIFT: begin
                    if (clk_fall) begin
                        kb_data_oe_q <= ~frame_q[0];
                        frame_q      <= {1'b0, frame_q[9:1]};
                        bit_cnt_q    <= bit_cnt_q + 1'b1;
                        cnt_q        <= '0;
                        if (bit_cnt_q == 4'd9) begin
                            state_q <= ACK;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        kb_clock_oe_q <= 1'b0;
                        kb_data_oe_q  <= 1'b0;
                        tx_error_q    <= 1'b1;
                        tx_ready_q    <= 1'b1;
                        busy_q        <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ACK: begin
                    if (clk_fall && !dat_s2_q) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_IDLE;
                    end else if (clk_fall || cnt_q == TO_LAST) begin
                        kb_clock_oe_q <= 1'b0;
                        kb_data_oe_q  <= 1'b0;
                        tx_error_q    <= 1'b1;
                        tx_ready_q    <= 1'b1;
                        busy_q        <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_s2_q && dat_s2_q) begin
                        tx_done_q  <= 1'b1;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= IDLE;
                    end else if (clk_fall) begin
                        cnt_q <= '0;
                    end else if (cnt_q == TO_LAST) begin
                        kb_clock_oe_q <= 1'b0;
                        kb_data_oe_q  <= 1'b0;
                        tx_error_q    <= 1'b1;
                        tx_ready_q    <= 1'b1;
                        busy_q        <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    kb_clock_oe_q <= 1'b0;
                    kb_data_oe_q  <= 1'b0;
                    tx_ready_q    <= 1'b1;
                    busy_q        <= 1'b0;
                    cnt_q         <= '0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    assign tx_if.tx_ready = tx_ready_q;
    assign kb_clock_oe    = kb_clock_oe_q;
    assign kb_data_oe     = kb_data_oe_q;
    assign busy           = busy_q;
    assign tx_done        = tx_done_q;
    assign tx_error       = tx_error_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a keyboard model clocks the frame out, samples each bit on its falling edge
// and ACKs; outcome pulses and sampled frames are checked against scoreboard queues.
module tb_ps2_tx;

    localparam int INH = 20;
    localparam int TO  = 400;

    logic       clk;
    logic       resetp;
    logic       dev_clk, dev_data;
    logic       keyboard_clock, keyboard_data;
    logic       kb_clock_oe, kb_data_oe;
    logic       busy, tx_done, tx_error;
    logic [2:0] dbg_state;

    ps2_tx_if tx_if ();

    ps2_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK_CPU       (clk),
        .resetp        (resetp),
        .tx_if         (tx_if),
        .keyboard_clock(keyboard_clock),
        .keyboard_data (keyboard_data),
        .kb_clock_oe   (kb_clock_oe),
        .kb_data_oe    (kb_data_oe),
        .busy          (busy),
        .tx_done       (tx_done),
        .tx_error      (tx_error),
        .dbg_state_o   (dbg_state)
    );

    // Open-drain bus: either side pulling low wins.
    assign keyboard_clock = ~kb_clock_oe & dev_clk;
    assign keyboard_data  = ~kb_data_oe & dev_data;

    // ---------------- clock / reset / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    logic [1:0]  exp_q[$];        // 2'b01 = tx_done, 2'b10 = tx_error
    logic [10:0] exp_frame_q[$];  // bit i = i-th bit sampled by the device

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (tx_done || tx_error) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got done=%0b error=%0b required none", tx_done, tx_error);
            end else begin
                check("outcome_pulse", {30'd0, tx_error, tx_done}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] d);
        int n;
        int inh;
        int st;
        @(negedge clk);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        n = 0;
        while (!tx_if.tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'd0, tx_if.tx_ready}, 32'd1);
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        inh = 0;
        while (kb_clock_oe && !kb_data_oe && inh < 200) begin
            inh++;
            @(negedge clk);
        end
        check("inhibit_cycles", inh, INH);
        st = 0;
        while (kb_clock_oe && kb_data_oe && st < 10) begin
            st++;
            @(negedge clk);
        end
        check("start_cycles", st, 1);
        check("shift_entry_oe", {30'd0, kb_clock_oe, kb_data_oe}, 32'b01);
    endtask

    // mode 0: ACK low, mode 1: no ACK, mode 2: reset pulse on the 5th fall
    task automatic dev_run(input int mode);
        logic [10:0] got;
        bit aborted;
        got = '0;
        aborted = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 11 && !aborted; i++) begin
            @(negedge clk);
            dev_clk = 1'b0;
            got[i] = keyboard_data;
            if (mode == 2 && i == 4) begin
                resetp = 1'b1;
                @(negedge clk);
                resetp = 1'b0;
                check("reset_mid_oe", {30'd0, kb_clock_oe, kb_data_oe}, 32'd0);
                check("reset_mid_ready_busy", {30'd0, tx_if.tx_ready, busy}, 32'b10);
                dev_clk = 1'b1;
                aborted = 1'b1;
            end else begin
                if (i == 10 && mode == 0) dev_data = 1'b0;
                repeat (20) @(negedge clk);
                dev_clk = 1'b1;
                if (i == 10) dev_data = 1'b1;
                repeat (19) @(negedge clk);
            end
        end
        if (!aborted) begin
            if (exp_frame_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got %b required no frame", got);
            end else begin
                check("device_frame", {21'd0, got}, {21'd0, exp_frame_q.pop_front()});
            end
        end
    endtask

    task automatic wait_idle_and_drain(input string name);
        int n;
        n = 0;
        while (!(tx_if.tx_ready && !busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        check({name, "_idle"}, {31'd0, tx_if.tx_ready}, 32'd1);
        check({name, "_pending"}, exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        resetp         = 1'b1;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        dev_clk        = 1'b1;
        dev_data       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_oe", {30'd0, kb_clock_oe, kb_data_oe}, 32'd0);
        check("reset_ready_busy", {30'd0, tx_if.tx_ready, busy}, 32'b10);
        check("reset_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        resetp = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED, parity 1, acknowledged
        exp_q.push_back(2'b01);
        exp_frame_q.push_back(11'b11111011010);
        send(8'hED);
        dev_run(0);
        wait_idle_and_drain("ed");

        // 0x07, parity 0, with an ignored tx_valid pulse mid-transfer
        exp_q.push_back(2'b01);
        exp_frame_q.push_back(11'b10000001110);
        send(8'h07);
        fork
            dev_run(0);
            begin
                repeat (100) @(negedge clk);
                tx_if.tx_data  = 8'hAA;
                tx_if.tx_valid = 1'b1;
                check("mid_valid_busy", {30'd0, busy, tx_if.tx_ready}, 32'b10);
                @(negedge clk);
                tx_if.tx_valid = 1'b0;
                check("mid_valid_still_busy", {31'd0, busy}, 32'd1);
            end
        join
        wait_idle_and_drain("x07");

        // device never clocks: timeout
        exp_q.push_back(2'b10);
        send(8'h55);
        n = 0;
        while (!tx_error && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_oe", {30'd0, kb_clock_oe, kb_data_oe}, 32'd0);
        @(negedge clk);
        check("timeout_ready_next", {30'd0, tx_if.tx_ready, tx_error}, 32'b10);
        wait_idle_and_drain("timeout");

        // no ACK on the 11th fall
        exp_q.push_back(2'b10);
        exp_frame_q.push_back(11'b11111111110);
        send(8'hFF);
        dev_run(1);
        wait_idle_and_drain("nack");

        // next request after the error is accepted and completes
        exp_q.push_back(2'b01);
        exp_frame_q.push_back(11'b11001111000);
        send(8'h3C);
        dev_run(0);
        wait_idle_and_drain("after_nack");

        // reset in the middle of the frame, then a clean 0xF4
        send(8'h12);
        dev_run(2);
        repeat (20) @(negedge clk);
        check("reset_mid_pulses", exp_q.size(), 0);
        exp_q.push_back(2'b01);
        exp_frame_q.push_back(11'b10111101000);
        send(8'hF4);
        dev_run(0);
        wait_idle_and_drain("f4");

        check("frames_pending", exp_frame_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
